// File: rtl/pcm_pkg.sv
// Shared definitions for the ADPCM playback sequencer.
package pcm_pkg;

  localparam int unsigned PAGE_BITS = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StHi    = 2'd2,
    StLo    = 2'd3
  } pcm_state_e;

endpackage

// File: rtl/pcm_rom_if.sv
// Request/acknowledge byte bus between the sequencer and the PCM ROM.
interface pcm_rom_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic                  rom_cs;
  logic [7:0]            rom_data;
  logic                  rom_ok;

  modport master (output rom_addr, output rom_cs, input rom_data, input rom_ok);
  modport slave  (input rom_addr, input rom_cs, output rom_data, output rom_ok);
endinterface

// File: rtl/pcm_rom_fetch.sv
// ROM handshake engine: one outstanding request, abort path and a one-byte prefetch buffer.
module pcm_rom_fetch #(
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  issue_i,       // start a request next cycle, dropping any other
  input  logic [ADDR_WIDTH-1:0] issue_addr_i,
  input  logic                  issue_buf_i,   // 1: prefetch into buffer, 0: demand fetch
  input  logic                  clr_i,         // drop request and invalidate the buffer
  output logic                  dem_ack_o,
  output logic [7:0]            rom_byte_o,
  output logic                  buf_valid_o,
  output logic [7:0]            buf_data_o,
  pcm_rom_if.master             rom
);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  cs_q, cs_d;
  logic                  to_buf_q, to_buf_d;
  logic [7:0]            buf_q, buf_d;
  logic                  buf_valid_q, buf_valid_d;
  logic                  ack;

  // rom_ok only counts while a request is actually outstanding.
  assign ack = cs_q & rom.rom_ok;

  // Request and buffer next-state; an issue always supersedes completion of the old request.
  always_comb begin
    addr_d      = addr_q;
    cs_d        = cs_q;
    to_buf_d    = to_buf_q;
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    if (ack) begin
      cs_d = 1'b0;
      if (to_buf_q) begin
        buf_d       = rom.rom_data;
        buf_valid_d = 1'b1;
      end
    end
    if (clr_i || issue_i) begin
      cs_d        = 1'b0;
      buf_valid_d = 1'b0;
    end
    if (issue_i) begin
      cs_d     = 1'b1;
      addr_d   = issue_addr_i;
      to_buf_d = issue_buf_i;
    end
  end

  // Handshake state registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      addr_q      <= '0;
      cs_q        <= 1'b0;
      to_buf_q    <= 1'b0;
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      cs_q        <= cs_d;
      to_buf_q    <= to_buf_d;
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  assign rom.rom_addr = addr_q;
  assign rom.rom_cs   = cs_q;
  assign dem_ack_o    = ack & ~to_buf_q;
  assign rom_byte_o   = rom.rom_data;
  assign buf_valid_o  = buf_valid_q;
  assign buf_data_o   = buf_q;

endmodule

// File: rtl/pcm_sequencer.sv
// ADPCM playback controller: page registers, byte pointer, nibble FSM and end compare.
module pcm_sequencer
  import pcm_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_strobe,
  input  logic [7:0] cpu_data,
  input  logic       start_wr,
  input  logic       end_wr,
  input  logic       stop_wr,
  pcm_rom_if.master  rom,
  output logic [3:0] nibble,
  output logic       decoder_rst,
  output logic       busy,
  output logic       underrun
);

  localparam int unsigned OffBits = ADDR_WIDTH - PAGE_BITS;

  pcm_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [PAGE_BITS-1:0]  start_page_q, start_page_d;
  logic [PAGE_BITS-1:0]  end_page_q, end_page_d;
  logic [3:0]            nibble_q, nibble_d;
  logic [3:0]            lo_nib_q, lo_nib_d;
  logic                  underrun_q, underrun_d;

  logic                  issue, issue_buf, clr;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic                  dem_ack, buf_valid;
  logic [7:0]            rom_byte, buf_data;

  logic [ADDR_WIDTH-1:0] start_base, end_base, ptr_inc, ptr_inc2;
  logic                  last, next_last;

  assign start_base = {start_page_q, {OffBits{1'b0}}};
  assign end_base   = {end_page_q, {OffBits{1'b0}}};
  assign ptr_inc    = ptr_q + ADDR_WIDTH'(1);
  assign ptr_inc2   = ptr_q + ADDR_WIDTH'(2);
  // Equality only, so a pointer that wraps past the end page keeps playing.
  assign last       = (ptr_inc == end_base);
  assign next_last  = (ptr_inc2 == end_base);

  pcm_rom_fetch #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_fetch (
    .clk_i       (clk),
    .reset_i     (reset),
    .issue_i     (issue),
    .issue_addr_i(issue_addr),
    .issue_buf_i (issue_buf),
    .clr_i       (clr),
    .dem_ack_o   (dem_ack),
    .rom_byte_o  (rom_byte),
    .buf_valid_o (buf_valid),
    .buf_data_o  (buf_data),
    .rom         (rom)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      start_page_q <= '0;
      end_page_q   <= '0;
      nibble_q     <= '0;
      lo_nib_q     <= '0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      start_page_q <= start_page_d;
      end_page_q   <= end_page_d;
      nibble_q     <= nibble_d;
      lo_nib_q     <= lo_nib_d;
      underrun_q   <= underrun_d;
    end
  end

  // Next state: stop beats go, go beats the strobe-driven sequencing.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    start_page_d = start_page_q;
    end_page_d   = end_page_q;
    nibble_d     = nibble_q;
    lo_nib_d     = lo_nib_q;
    underrun_d   = underrun_q;
    issue        = 1'b0;
    issue_addr   = ptr_inc;
    issue_buf    = 1'b1;
    clr          = 1'b0;

    if (start_wr) start_page_d = cpu_data;
    if (end_wr)   end_page_d   = cpu_data;

    if (stop_wr) begin
      state_d = StIdle;
      clr     = 1'b1;
    end else if (end_wr) begin
      clr = 1'b1;
      if (cpu_data == start_page_q) begin
        state_d = StIdle;
      end else begin
        state_d    = StFetch;
        ptr_d      = start_base;
        issue      = 1'b1;
        issue_addr = start_base;
        issue_buf  = 1'b0;
        underrun_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        StIdle: ;
        StFetch: begin
          if (sample_strobe) underrun_d = 1'b1;
          if (dem_ack) begin
            state_d  = StHi;
            nibble_d = rom_byte[7:4];
            lo_nib_d = rom_byte[3:0];
            issue    = !last;
          end
        end
        StHi: begin
          if (sample_strobe) begin
            state_d  = StLo;
            nibble_d = lo_nib_q;
          end
        end
        StLo: begin
          if (sample_strobe) begin
            if (last) begin
              state_d = StIdle;
              clr     = 1'b1;
            end else if (buf_valid) begin
              ptr_d      = ptr_inc;
              state_d    = StHi;
              nibble_d   = buf_data[7:4];
              lo_nib_d   = buf_data[3:0];
              issue      = !next_last;
              issue_addr = ptr_inc2;
              clr        = 1'b1;
            end else begin
              // Prefetch still in flight: restart it as a demand fetch.
              ptr_d     = ptr_inc;
              state_d   = StFetch;
              issue     = 1'b1;
              issue_buf = 1'b0;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs decoded from state.
  always_comb begin
    decoder_rst = 1'b1;
    busy        = 1'b0;
    if (state_q != StIdle) begin
      decoder_rst = 1'b0;
      busy        = 1'b1;
    end
  end

  assign nibble   = nibble_q;
  assign underrun = underrun_q;

endmodule
